// File: rtl/rst_seq_pkg.sv
//------------------------------------------------------------------------------
// rst_seq_pkg : shared types and helpers for the reset sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int EVT_CNT_W = 16;

  // Timer must hold the larger of the two intervals it measures.
  function automatic int timer_width(input int stretch, input int stagger);
    int mx;
    mx = (stretch > stagger) ? stretch : stagger;
    return $clog2(mx + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_seq_timer.sv
//------------------------------------------------------------------------------
// rst_seq_timer : saturating up-counter with restart and terminal-count compare
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rst_seq_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // A restart loads 1: the accepting edge is itself the first counted edge.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = WIDTH'(1);
    end else if (cnt_q < term_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q >= term_i);

endmodule

`default_nettype wire

// File: rtl/rst_seq.sv
//------------------------------------------------------------------------------
// rst_seq : N-channel reset sequencer with stretch and staggered release.
// Optional event counter port evt_cnt enabled by macro RST_SEQ_CNT_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int STRETCH = 8,
  parameter int STAGGER = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [N_CH-1:0]      ch_mask,
  output logic [N_CH-1:0]      rst_out,
  output logic                 busy,
  output logic                 done
`ifdef RST_SEQ_CNT_EN
  ,
  output logic [EVT_CNT_W-1:0] evt_cnt
`endif
);

  localparam int TW = timer_width(STRETCH, STAGGER);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

  state_e          state_q, state_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;

  logic            accept;
  logic            restart;
  logic            tc;
  logic [TW-1:0]   term;
  logic            slot;
  logic [IW-1:0]   slot_idx;

  assign accept = req & (|ch_mask);
  assign term   = (state_q == ST_ASSERT) ? TW'(STRETCH) : TW'(STAGGER);

  rst_seq_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .term_i    (term),
    .tc_o      (tc)
  );

  // mask_q is both the active mask and the live rst_out: released bits drop out.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    restart  = 1'b0;
    slot     = 1'b0;
    slot_idx = idx_q;
    case (state_q)
      ST_ASSERT: begin
        if (accept) begin
          mask_d  = mask_q | ch_mask;
          restart = 1'b1;
        end else if (tc) begin
          slot     = 1'b1;
          slot_idx = '0;
        end
      end
      ST_RELEASE: begin
        if (accept) begin
          state_d = ST_ASSERT;
          mask_d  = mask_q | ch_mask;
          restart = 1'b1;
        end else if (tc) begin
          slot = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          state_d = ST_ASSERT;
          mask_d  = ch_mask;
          restart = 1'b1;
        end
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase

    // Slot 0 fires on the edge that leaves ASSERT, later slots every STAGGER edges.
    if (slot) begin
      mask_d[slot_idx] = 1'b0;
      if (slot_idx == LAST_IDX) begin
        state_d = ST_RUN;
        mask_d  = '0;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RELEASE;
        idx_d   = slot_idx + IW'(1);
        restart = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ASSERT;
      mask_q  <= '1;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign rst_out = mask_q;
  assign busy    = (state_q != ST_RUN);
  assign done    = done_q;

`ifdef RST_SEQ_CNT_EN
  logic [EVT_CNT_W-1:0] evt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= '0;
    end else if (accept && (evt_q != '1)) begin
      evt_q <= evt_q + EVT_CNT_W'(1);
    end
  end

  assign evt_cnt = evt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
//------------------------------------------------------------------------------
// tb_rst_seq : directed and random stimulus against a schedule-based model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rst_seq;

  localparam int N_CH    = 4;
  localparam int STRETCH = 8;
  localparam int STAGGER = 2;
  localparam int LAST_E  = STRETCH + (N_CH - 1) * STAGGER;

  logic            clk = 1'b0;
  logic            rst;
  logic            req;
  logic [N_CH-1:0] ch_mask;
  logic [N_CH-1:0] rst_out;
  logic            busy;
  logic            done;
`ifdef RST_SEQ_CNT_EN
  logic [15:0]     evt_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: edge index since the schedule's edge 0 and per-channel levels.
  logic [N_CH-1:0] m_hi;
  bit              m_seq;
  bit              m_done;
  int              m_next_e;
  int              m_evt;

  always #5 clk = ~clk;

  rst_seq #(
    .N_CH    (N_CH),
    .STRETCH (STRETCH),
    .STAGGER (STAGGER)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ch_mask (ch_mask),
    .rst_out (rst_out),
    .busy    (busy),
    .done    (done)
`ifdef RST_SEQ_CNT_EN
    ,
    .evt_cnt (evt_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    int e;
    m_done = 1'b0;
    if (rst) begin
      m_hi     = '1;
      m_seq    = 1'b1;
      m_next_e = 0;
      m_evt    = 0;
    end else if (req && (ch_mask != '0)) begin
      m_hi     = m_hi | ch_mask;
      m_seq    = 1'b1;
      m_next_e = 1;
      if (m_evt < 65535) m_evt++;
    end else if (m_seq) begin
      e = m_next_e;
      for (int i = 0; i < N_CH; i++) begin
        if (e == STRETCH + i * STAGGER) m_hi[i] = 1'b0;
      end
      if (e == LAST_E) begin
        m_seq  = 1'b0;
        m_done = 1'b1;
      end
      m_next_e = e + 1;
    end
  endtask

  task automatic cycle(input logic r, input logic q, input logic [N_CH-1:0] m);
    rst     = r;
    req     = q;
    ch_mask = m;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("rst_out", 32'(rst_out), 32'(m_hi));
    check("busy",    32'(busy),    32'(m_seq));
    check("done",    32'(done),    32'(m_done));
`ifdef RST_SEQ_CNT_EN
    check("evt_cnt", 32'(evt_cnt), 32'(m_evt));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  int done_seen;

  initial begin
    rst     = 1'b1;
    req     = 1'b0;
    ch_mask = '0;

    // Power-up sequence with the fixed constants of the default schedule.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
    check("reset_rst_out", 32'(rst_out), 32'hF);
    check("reset_busy",    32'(busy),    32'd1);
    done_seen = 0;
    for (int e = 0; e < 20; e++) begin
      cycle(1'b0, 1'b0, '0);
      if (done) done_seen++;
      if (e == 7)  check("edge7_all_high", 32'(rst_out), 32'hF);
      if (e == 8)  check("edge8_bit0",     32'(rst_out), 32'hE);
      if (e == 13) check("edge13_bit3",    32'(rst_out), 32'h8);
      if (e == 14) check("edge14_done",    32'(done),    32'd1);
      if (e == 14) check("edge14_busy",    32'(busy),    32'd0);
    end
    check("done_once", 32'(done_seen), 32'd1);

    // Soft request from RUN with a partial mask.
    cycle(1'b0, 1'b1, 4'b0101);
    check("soft_req_mask", 32'(rst_out), 32'h5);
    idle(20);

    // Zero-mask requests are ignored.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'b0000);
    check("zero_mask_busy", 32'(busy), 32'd0);

    // Extension during ASSERT.
    cycle(1'b1, 1'b0, '0);
    idle(5);
    cycle(1'b0, 1'b1, 4'b0001);
    idle(24);

    // Interrupt RELEASE after bits 0 and 1 are released.
    cycle(1'b1, 1'b0, '0);
    idle(11);
    cycle(1'b0, 1'b1, 4'b0001);
    check("interrupt_mask", 32'(rst_out), 32'hD);
    idle(24);

    // Hard reset in the middle of RELEASE.
    cycle(1'b1, 1'b0, '0);
    idle(11);
    cycle(1'b1, 1'b0, '0);
    check("midrel_rst_out", 32'(rst_out), 32'hF);
    idle(20);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 9) == 0),
            N_CH'($urandom));
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rst_seq.md
# rst_seq

Parametrised synchronous reset sequencer: it generalises the single-flop synchronous reset into an N-channel reset generator. A hard reset or a masked soft-reset request holds each channel's reset for a minimum stretch period. The channels are then released one at a time in fixed index order, with a programmable stagger between releases. It sits at the top of each subsystem and drives the local reset of downstream blocks.

## Interface
- N_CH, 4: number of reset channels (≥1)
- STRETCH, 8: minimum assertion length in cycles after the last cause (≥1)
- STAGGER, 2: cycles between consecutive channel releases (≥1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  hard reset; synchronous, active-high; resets every channel
- req  in  1  soft-reset request, sampled every cycle
- ch_mask  in  N_CH  channels affected by req
- rst_out  out  N_CH  per-channel reset, active-high, registered
- busy  out  1  high whenever a sequence is in progress
- done  out  1  one-cycle pulse when a sequence completes

## Operation
- States are ASSERT, RELEASE and RUN. busy = (state != RUN).
- While rst=1:
  - state=ASSERT, timer=0, active mask = all ones.
  - rst_out = all ones, busy=1, done=0.
  - req is ignored.
- ASSERT:
  - The timer counts edges. After STRETCH edges the block enters RELEASE.
  - req with ch_mask≠0: active mask |= ch_mask, rst_out |= ch_mask, timer restarts at 0.
- RELEASE:
  - Slot i (i = 0..N_CH-1) occurs i·STAGGER edges after RELEASE entry.
  - At slot i, bit i of rst_out clears.
  - Channels outside the active mask are already low but still consume their slot, so timing is mask-independent.
  - After slot N_CH-1: state=RUN, active mask cleared, done=1 for exactly one cycle.
- RELEASE interrupted by req with ch_mask≠0:
  - Return to ASSERT with timer=0.
  - Active mask = (channels not yet released) | ch_mask; rst_out follows it.
  - Released channels outside ch_mask stay low.
- RUN:
  - req with ch_mask≠0 enters ASSERT; rst_out = ch_mask; other bits stay 0.
  - req with ch_mask=0 is ignored everywhere: no state change, no busy.
- rst during any state overrides everything on the same edge.

## Timing
- Reset values: rst_out all ones, busy=1, done=0.
- Edge numbering: edge 0 is the first edge that samples rst=0, or the edge that accepts req in RUN.
- rst_out bit i (if active) falls after edge STRETCH + i·STAGGER.
- busy falls and done rises after edge STRETCH + (N_CH-1)·STAGGER. done falls on the next edge.
- Soft request from RUN: rst_out rises after edge 0 (one-cycle latency from req).
- Extension in ASSERT: the release schedule restarts from the edge that accepted the new req.
- Defaults example: releases after edges 8, 10, 12, 14; done high in the cycle after edge 14.
- Timer width: $clog2(max(STRETCH, STAGGER)+1); no wrap, it saturates at its terminal value.

## Configuration
- Macro RST_SEQ_CNT_EN.
- Defined: adds output port evt_cnt (16 bits).
  - Increments on each accepted soft request (req & |ch_mask, rst=0), including extensions in ASSERT and RELEASE.
  - Saturates at 16'hFFFF and is cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package rst_seq_pkg holds:
  - the state enum typedef (ST_ASSERT, ST_RELEASE, ST_RUN);
  - the event-counter width constant (16);
  - a function returning the timer width from STRETCH/STAGGER.
- One sub-module, rst_seq_timer: saturating up-counter with synchronous clear and terminal-count compare, reused for both the stretch and stagger intervals.
- The FSM, active mask and channel index live in rst_seq.

## Test plan
- Defaults; rst high 3 cycles then low → rst_out=4'hF through edge 7; bits 0..3 fall after edges 8/10/12/14; done pulses once; busy falls after edge 14.
- In RUN, req=1 with ch_mask=4'b0101 for one cycle → rst_out=4'b0101 next cycle; bit 0 clears after edge 8, bit 2 after edge 12; bits 1 and 3 never rise; done after edge 14.
- req with ch_mask=4'b0001 at edge 5 of ASSERT → release schedule restarts; bit 0 falls 8 edges after that req.
- req with ch_mask=4'b0001 during RELEASE, after bits 0 and 1 released → rst_out=4'b1101; re-enters ASSERT; full schedule reruns.
- rst asserted mid-RELEASE → rst_out=4'hF, busy=1, done=0 on the next cycle; req with ch_mask=0 in RUN → no change.
- With RST_SEQ_CNT_EN: three accepted requests → evt_cnt=3; rst → 0; forcing near 16'hFFFF confirms saturation.
